// File: rtl/spi_shift_mlane_if.sv
// Bus bundle between the SPI host control/clock-gen logic and the multi-lane shift engine.
// Latency: none, wiring only.
// Backpressure: none; transfers are paced by the sclk edge strobes, not by a handshake.
interface spi_shift_mlane_if #(
  parameter int MAX_CHAR = 128
);
  localparam int LEN_W  = $clog2(MAX_CHAR);
  localparam int NWORDS = MAX_CHAR / 32;

  logic [NWORDS-1:0]   latch;
  logic [3:0]          byte_sel;
  logic [31:0]         p_in;
  logic [LEN_W-1:0]    len;
  logic [1:0]          mode;
  logic                lsb;
  logic                dir;
  logic                go;
  logic                pos_edge;
  logic                neg_edge;
  logic                rx_negedge;
  logic                tx_negedge;
  logic                tip;
  logic                last;
  logic                done;
  logic [MAX_CHAR-1:0] p_out;
  logic [3:0]          s_in;
  logic [3:0]          s_out;
  logic [3:0]          s_oe;

  // Host side: register/clock-gen logic plus pad inputs.
  modport master (
    output latch, byte_sel, p_in, len, mode, lsb, dir, go,
    output pos_edge, neg_edge, rx_negedge, tx_negedge, s_in,
    input  tip, last, done, p_out, s_out, s_oe
  );

  // Shift engine side.
  modport slave (
    input  latch, byte_sel, p_in, len, mode, lsb, dir, go,
    input  pos_edge, neg_edge, rx_negedge, tx_negedge, s_in,
    output tip, last, done, p_out, s_out, s_oe
  );
endinterface

// File: rtl/spi_shift_mlane.sv
// In-place MAX_CHAR-bit SPI shift engine on 1/2/4 lanes; SPI_SHIFT_QUAD_EN enables quad mode (mode 10).
// Latency: go -> LOAD (beat 0 on s_out) -> ACTIVE next clk; done pulses one clk after the final rx strobe.
// Backpressure: none; beats advance only on pos_edge/neg_edge strobes, latch/go ignored while busy.
module spi_shift_mlane #(
  parameter int MAX_CHAR = 128
) (
  input logic              clk,
  input logic              rst_n,
  spi_shift_mlane_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_CHAR);
  localparam int NWORDS = MAX_CHAR / 32;
  localparam int CNT_W  = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, FINISH} state_t;

  state_t              state;
  logic [MAX_CHAR-1:0] data;
  logic [LEN_W-1:0]    len_q;
  logic [1:0]          mode_q;
  logic                lsb_q;
  logic                dir_q;
  logic                rxn_q;
  logic                txn_q;
  logic [CNT_W-1:0]    tx_beat;
  logic [CNT_W-1:0]    rx_beat;
  logic                tip_q;
  logic                last_q;
  logic                done_q;
  logic [3:0]          s_out_q;
  logic [3:0]          s_oe_q;

  logic [1:0]          lane_sh;
  int                  lanes;
  logic [CNT_W-1:0]    nbits;
  logic [CNT_W-1:0]    nbeats;
  logic [CNT_W-1:0]    last_beat;
  logic [3:0]          oe_mask;
  logic [3:0]          rx_lanes;
  logic [3:0]          tx_first;
  logic [3:0]          tx_next;
  logic [MAX_CHAR-1:0] rx_data;
  logic                tx_edge;
  logic                rx_edge;

  // Bit position carried by a lane in a given beat; may fall outside 0..n-1 on a partial last beat.
  function automatic int lane_pos(input int beat, input int lane, input int k, input int n,
                                  input logic lsb_first);
    if (lsb_first) lane_pos = beat * k + lane;
    else           lane_pos = n - beat * k - k + lane;
  endfunction

  // Lane values to drive for a beat; lanes beyond k or off the end of the character read as 0.
  function automatic logic [3:0] beat_bits(input logic [MAX_CHAR-1:0] d, input int beat,
                                           input int k, input int n, input logic lsb_first);
    int p;
    beat_bits = '0;
    for (int l = 0; l < 4; l++) begin
      p = lane_pos(beat, l, k, n, lsb_first);
      if (l < k && p >= 0 && p < n) beat_bits[l] = d[p[LEN_W-1:0]];
    end
  endfunction

  // Decode the captured transfer config into lane count, character size and beat count.
  always_comb begin
`ifdef SPI_SHIFT_QUAD_EN
    case (mode_q)
      2'b01:   lane_sh = 2'd1;
      2'b10:   lane_sh = 2'd2;
      default: lane_sh = 2'd0;
    endcase
`else
    lane_sh = (mode_q == 2'b01) ? 2'd1 : 2'd0;
`endif
    lanes     = 1 << lane_sh;
    nbits     = (len_q == '0) ? CNT_W'(MAX_CHAR) : {1'b0, len_q};
    nbeats    = (nbits + CNT_W'(lanes - 1)) >> lane_sh;
    last_beat = nbeats - CNT_W'(1);
    case (lane_sh)
      2'd1:    oe_mask = {2'b00, dir_q, dir_q};
      2'd2:    oe_mask = {4{dir_q}};
      default: oe_mask = 4'b0001;
    endcase
    // Single mode samples MISO on lane 1 but files it as lane 0 of the beat.
    case (lane_sh)
      2'd1:    rx_lanes = {2'b00, bus.s_in[1:0]};
      2'd2:    rx_lanes = bus.s_in;
      default: rx_lanes = {3'b000, bus.s_in[1]};
    endcase
    tx_edge = txn_q ? bus.neg_edge : bus.pos_edge;
    rx_edge = rxn_q ? bus.neg_edge : bus.pos_edge;
  end

  // Next tx lane values and the register image after merging the current rx beat.
  always_comb begin
    int p;
    p        = 0;
    tx_first = beat_bits(data, 0, lanes, int'(nbits), lsb_q) & oe_mask;
    tx_next  = beat_bits(data, int'(tx_beat) + 1, lanes, int'(nbits), lsb_q) & oe_mask;
    rx_data  = data;
    for (int l = 0; l < 4; l++) begin
      p = lane_pos(int'(rx_beat), l, lanes, int'(nbits), lsb_q);
      if (l < lanes && p >= 0 && p < int'(nbits)) rx_data[p[LEN_W-1:0]] = rx_lanes[l];
    end
  end

  // Transfer sequencer: owns the shift register, beat counters and every registered pad output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data    <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      lsb_q   <= 1'b0;
      dir_q   <= 1'b0;
      rxn_q   <= 1'b0;
      txn_q   <= 1'b0;
      tx_beat <= '0;
      rx_beat <= '0;
      tip_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      s_out_q <= '0;
      s_oe_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Writes land before LOAD reads data, so go alongside latch sees the new word.
          for (int i = 0; i < NWORDS; i++) begin
            for (int b = 0; b < 4; b++) begin
              if (bus.latch[i] && bus.byte_sel[b]) data[32*i + 8*b +: 8] <= bus.p_in[8*b +: 8];
            end
          end
          if (bus.go) begin
            len_q  <= bus.len;
            mode_q <= bus.mode;
            lsb_q  <= bus.lsb;
            dir_q  <= bus.dir;
            rxn_q  <= bus.rx_negedge;
            txn_q  <= bus.tx_negedge;
            tip_q  <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          s_out_q <= tx_first;
          s_oe_q  <= oe_mask;
          tx_beat <= '0;
          rx_beat <= '0;
          last_q  <= (last_beat == '0);
          state   <= ACTIVE;
        end
        ACTIVE: begin
          if (tx_edge && tx_beat < last_beat) begin
            tx_beat <= tx_beat + CNT_W'(1);
            s_out_q <= tx_next;
          end
          if (rx_edge) begin
            data <= rx_data;
            if (rx_beat == last_beat) begin
              // Final beat: release the pads in the same clk that done rises.
              tip_q   <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              s_out_q <= '0;
              s_oe_q  <= '0;
              state   <= FINISH;
            end else begin
              rx_beat <= rx_beat + CNT_W'(1);
              last_q  <= (rx_beat + CNT_W'(1) == last_beat);
            end
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tip   = tip_q;
  assign bus.last  = last_q;
  assign bus.done  = done_q;
  assign bus.p_out = data;
  assign bus.s_out = s_out_q;
  assign bus.s_oe  = s_oe_q;
endmodule
